// File: rtl/reg_bus_master.sv
// Register-bus initiator: turns a byte-stream command channel into register read/write bursts
// on the shared reg_* bus and returns read bytes on a response stream.
module reg_bus_master #(
  parameter int pBYTECNT_SIZE = 7
) (
  input  logic                     cwusb_clk,
  input  logic                     reset_i,
  input  logic [7:0]               I_cmd_data,
  input  logic                     I_cmd_valid,
  output logic                     O_cmd_ready,
  output logic [7:0]               O_rsp_data,
  output logic                     O_rsp_valid,
  input  logic                     I_rsp_ready,
  output logic [7:0]               reg_address,
  output logic [pBYTECNT_SIZE-1:0] reg_bytecnt,
  output logic [7:0]               write_data,
  input  logic [7:0]               read_data,
  output logic                     reg_read,
  output logic                     reg_write,
  output logic                     reg_addrvalid,
  output logic                     O_busy,
  output logic                     O_bad_opcode
);

  typedef enum logic [2:0] {
    S_OPCODE,
    S_ADDR,
    S_LEN,
    S_WR,
    S_RD_STROBE,
    S_RD_CAP,
    S_RD_OUT,
    S_END
  } state_t;

  localparam logic [7:0]               OP_WRITE = 8'h00;
  localparam logic [7:0]               OP_READ  = 8'h01;
  localparam logic [pBYTECNT_SIZE-1:0] IDX_ONE  = pBYTECNT_SIZE'(1);

  state_t                   state;
  logic                     is_read;
  logic [pBYTECNT_SIZE-1:0] idx;
  logic [pBYTECNT_SIZE-1:0] last_idx;
  logic                     cmd_hs;

  assign cmd_hs = I_cmd_valid & O_cmd_ready;
  assign O_busy = (state != S_OPCODE);

  always_ff @(posedge cwusb_clk) begin
    if (reset_i) begin
      state         <= S_OPCODE;
      is_read       <= 1'b0;
      idx           <= '0;
      last_idx      <= '0;
      O_cmd_ready   <= 1'b0;
      O_rsp_data    <= '0;
      O_rsp_valid   <= 1'b0;
      reg_address   <= '0;
      reg_bytecnt   <= '0;
      write_data    <= '0;
      reg_read      <= 1'b0;
      reg_write     <= 1'b0;
      reg_addrvalid <= 1'b0;
      O_bad_opcode  <= 1'b0;
    end else begin
      reg_read     <= 1'b0;
      reg_write    <= 1'b0;
      O_bad_opcode <= 1'b0;
      case (state)
        S_OPCODE: begin
          O_cmd_ready <= 1'b1;
          if (cmd_hs) begin
            if (I_cmd_data == OP_WRITE || I_cmd_data == OP_READ) begin
              is_read <= (I_cmd_data == OP_READ);
              state   <= S_ADDR;
            end else begin
              O_bad_opcode <= 1'b1;
            end
          end
        end
        S_ADDR: begin
          if (cmd_hs) begin
            reg_address <= I_cmd_data;
            state       <= S_LEN;
          end
        end
        S_LEN: begin
          if (cmd_hs) begin
            last_idx      <= I_cmd_data[pBYTECNT_SIZE-1:0];
            idx           <= '0;
            reg_addrvalid <= 1'b1;
            // The first read strobe is issued together with the rise of reg_addrvalid.
            if (is_read) begin
              O_cmd_ready <= 1'b0;
              reg_read    <= 1'b1;
              reg_bytecnt <= '0;
              state       <= S_RD_STROBE;
            end else begin
              state <= S_WR;
            end
          end
        end
        S_WR: begin
          if (cmd_hs) begin
            reg_write   <= 1'b1;
            write_data  <= I_cmd_data;
            reg_bytecnt <= idx;
            idx         <= idx + IDX_ONE;
            if (idx == last_idx) begin
              O_cmd_ready <= 1'b0;
              state       <= S_END;
            end
          end
        end
        S_RD_STROBE: begin
          state <= S_RD_CAP;
        end
        S_RD_CAP: begin
          O_rsp_data  <= read_data;
          O_rsp_valid <= 1'b1;
          state       <= S_RD_OUT;
        end
        S_RD_OUT: begin
          if (I_rsp_ready) begin
            O_rsp_valid <= 1'b0;
            if (idx != last_idx) begin
              idx         <= idx + IDX_ONE;
              reg_bytecnt <= idx + IDX_ONE;
              reg_read    <= 1'b1;
              state       <= S_RD_STROBE;
            end else begin
              reg_addrvalid <= 1'b0;
              state         <= S_END;
            end
          end
        end
        S_END: begin
          reg_addrvalid <= 1'b0;
          O_cmd_ready   <= 1'b1;
          state         <= S_OPCODE;
        end
        default: begin
          state <= S_OPCODE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_master.sv
// Bench for reg_bus_master: a table of command vectors drives a scoreboard of expected bus
// strobes and response bytes, plus a hand-written mid-burst reset sequence.
module tb_reg_bus_master;
  localparam int W = 7;

  logic           cwusb_clk = 1'b0;
  logic           reset_i;
  logic [7:0]     I_cmd_data;
  logic           I_cmd_valid;
  logic           O_cmd_ready;
  logic [7:0]     O_rsp_data;
  logic           O_rsp_valid;
  logic           I_rsp_ready;
  logic [7:0]     reg_address;
  logic [W-1:0]   reg_bytecnt;
  logic [7:0]     write_data;
  logic [7:0]     read_data;
  logic           reg_read;
  logic           reg_write;
  logic           reg_addrvalid;
  logic           O_busy;
  logic           O_bad_opcode;

  always #5 cwusb_clk = ~cwusb_clk;

  reg_bus_master #(.pBYTECNT_SIZE(W)) dut (
    .cwusb_clk     (cwusb_clk),
    .reset_i       (reset_i),
    .I_cmd_data    (I_cmd_data),
    .I_cmd_valid   (I_cmd_valid),
    .O_cmd_ready   (O_cmd_ready),
    .O_rsp_data    (O_rsp_data),
    .O_rsp_valid   (O_rsp_valid),
    .I_rsp_ready   (I_rsp_ready),
    .reg_address   (reg_address),
    .reg_bytecnt   (reg_bytecnt),
    .write_data    (write_data),
    .read_data     (read_data),
    .reg_read      (reg_read),
    .reg_write     (reg_write),
    .reg_addrvalid (reg_addrvalid),
    .O_busy        (O_busy),
    .O_bad_opcode  (O_bad_opcode)
  );

  // Cycle stamp, stable when read on the falling edge.
  int unsigned cyc = 0;
  always @(posedge cwusb_clk) cyc <= cyc + 1;

  // Model slave: answers 0x10+bytecnt the cycle after a read strobe, 0 otherwise.
  logic [7:0] slave_q = 8'h00;
  always @(posedge cwusb_clk) slave_q <= reg_read ? (8'h10 + {1'b0, reg_bytecnt}) : 8'h00;
  assign read_data = slave_q;

  typedef struct {
    logic [7:0]   addr;
    logic [W-1:0] cnt;
    logic [7:0]   data;
  } bus_ev_t;

  typedef struct {
    bit         has_pre;
    logic [7:0] pre;
    logic [7:0] op;
    logic [7:0] addr;
    logic [7:0] len;
    logic [7:0] base;
    logic [7:0] step;
    bit         toggle;
    int         stall;
    int         exp_n;
    int         exp_bad;
  } vec_t;

  bus_ev_t     exp_wr[$];
  bus_ev_t     exp_rd[$];
  logic [7:0]  exp_rsp[$];
  logic [7:0]  cmd_q[$];

  int checks = 0;
  int failures = 0;

  int          rsp_stall = 0;
  int          n_wr = 0, n_rd = 0, n_rsp = 0, n_bad = 0, n_rise = 0, n_fall = 0;
  int unsigned rise_cyc = 0, fall_cyc = 0, last_wr_cyc = 0, last_rsp_cyc = 0, len_cyc = 0;
  logic        busy_at_fall = 1'b0;
  bit          rd_pending = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic monitor();
    bus_ev_t    e;
    logic       acc;
    logic       prev_valid = 1'b0, prev_acc = 1'b0, prev_av = 1'b0;
    logic [7:0] prev_data = 8'h00;
    int         wait_cnt = 0;
    logic [7:0] r;
    forever begin
      @(negedge cwusb_clk);
      // Ready is chosen first so the accept below matches what the DUT sees at the next edge.
      if (O_rsp_valid) begin
        if (wait_cnt < rsp_stall) begin
          I_rsp_ready = 1'b0;
          wait_cnt++;
        end else begin
          I_rsp_ready = 1'b1;
          wait_cnt = 0;
        end
      end else begin
        I_rsp_ready = (rsp_stall == 0);
        wait_cnt = 0;
      end

      if (reg_read || reg_write) chk("rd_wr_exclusive", 32'(reg_read & reg_write), 0);
      if (reg_write) begin
        n_wr++;
        last_wr_cyc = cyc;
        chk("wr_addrvalid", 32'(reg_addrvalid), 1);
        chk("wr_expected", 32'(exp_wr.size() > 0), 1);
        if (exp_wr.size() > 0) begin
          e = exp_wr.pop_front();
          chk("wr_addr", 32'(reg_address), 32'(e.addr));
          chk("wr_bytecnt", 32'(reg_bytecnt), 32'(e.cnt));
          chk("wr_data", 32'(write_data), 32'(e.data));
        end
      end
      if (reg_read) begin
        n_rd++;
        chk("rd_addrvalid", 32'(reg_addrvalid), 1);
        chk("rd_nonspeculative", 32'(rd_pending), 0);
        rd_pending = 1'b1;
        chk("rd_expected", 32'(exp_rd.size() > 0), 1);
        if (exp_rd.size() > 0) begin
          e = exp_rd.pop_front();
          chk("rd_addr", 32'(reg_address), 32'(e.addr));
          chk("rd_bytecnt", 32'(reg_bytecnt), 32'(e.cnt));
        end
      end
      if (O_rsp_valid && prev_valid && !prev_acc) chk("rsp_stable", 32'(O_rsp_data), 32'(prev_data));
      acc = O_rsp_valid && I_rsp_ready;
      if (acc) begin
        n_rsp++;
        last_rsp_cyc = cyc;
        rd_pending = 1'b0;
        chk("rsp_expected", 32'(exp_rsp.size() > 0), 1);
        if (exp_rsp.size() > 0) begin
          r = exp_rsp.pop_front();
          chk("rsp_data", 32'(O_rsp_data), 32'(r));
        end
      end
      if (O_bad_opcode) n_bad++;
      if (reg_addrvalid && !prev_av) begin
        n_rise++;
        rise_cyc = cyc;
      end
      if (!reg_addrvalid && prev_av) begin
        n_fall++;
        fall_cyc = cyc;
        busy_at_fall = O_busy;
      end
      prev_valid = O_rsp_valid;
      prev_acc   = acc;
      prev_data  = O_rsp_data;
      prev_av    = reg_addrvalid;
    end
  endtask

  task automatic drive(input bit toggle, input int len_pos, input int budget);
    int k = 0;
    int t = 0;
    bit ph = 1'b1;
    bit hs;
    while (cmd_q.size() > 0 && t < budget) begin
      @(negedge cwusb_clk);
      t++;
      I_cmd_valid = toggle ? ph : 1'b1;
      ph = ~ph;
      I_cmd_data = cmd_q[0];
      hs = I_cmd_valid && O_cmd_ready;
      if (hs && k == len_pos) len_cyc = cyc;
      @(posedge cwusb_clk);
      if (hs) begin
        cmd_q.delete(0);
        k++;
      end
    end
    @(negedge cwusb_clk);
    I_cmd_valid = 1'b0;
    chk("cmd_drained", 32'(cmd_q.size()), 0);
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while ((exp_wr.size() + exp_rd.size() + exp_rsp.size() != 0 || O_busy || reg_addrvalid)
           && t < budget) begin
      @(negedge cwusb_clk);
      t++;
    end
    chk("idle_reached", 32'(t < budget), 1);
    repeat (3) @(negedge cwusb_clk);
  endtask

  task automatic run_vec(input vec_t v);
    int         len_pos;
    int         b_wr, b_rd, b_rsp, b_bad, b_rise, b_fall;
    logic [7:0] d;
    bit         is_wr;
    is_wr = (v.op == 8'h00);
    b_wr = n_wr; b_rd = n_rd; b_rsp = n_rsp; b_bad = n_bad; b_rise = n_rise; b_fall = n_fall;
    rsp_stall = v.stall;
    cmd_q.delete();
    if (v.has_pre) cmd_q.push_back(v.pre);
    cmd_q.push_back(v.op);
    cmd_q.push_back(v.addr);
    cmd_q.push_back(v.len);
    len_pos = cmd_q.size() - 1;
    for (int i = 0; i < v.exp_n; i++) begin
      if (is_wr) begin
        d = 8'(int'(v.base) + int'(v.step) * i);
        cmd_q.push_back(d);
        exp_wr.push_back('{v.addr, W'(i), d});
      end else begin
        exp_rd.push_back('{v.addr, W'(i), 8'h00});
        exp_rsp.push_back(8'(16 + i));
      end
    end
    drive(v.toggle, len_pos, 3000);
    wait_idle(3000);
    chk("n_writes", n_wr - b_wr, is_wr ? v.exp_n : 0);
    chk("n_reads", n_rd - b_rd, is_wr ? 0 : v.exp_n);
    chk("n_responses", n_rsp - b_rsp, is_wr ? 0 : v.exp_n);
    chk("n_bad_opcode", n_bad - b_bad, v.exp_bad);
    chk("addrvalid_rises", n_rise - b_rise, 1);
    chk("addrvalid_falls", n_fall - b_fall, 1);
    chk("addrvalid_rise_cycle", rise_cyc, len_cyc + 1);
    if (is_wr) begin
      chk("addrvalid_fall_after_wr", fall_cyc, last_wr_cyc + 1);
      chk("busy_at_fall", 32'(busy_at_fall), 0);
      if (!v.toggle) chk("wr_back_to_back", last_wr_cyc, len_cyc + 1 + v.exp_n);
    end else begin
      chk("addrvalid_fall_after_rsp", fall_cyc, last_rsp_cyc + 1);
    end
  endtask

  vec_t vt[8];

  initial begin
    // has_pre, pre, op, addr, len, base, step, toggle, stall, exp_n, exp_bad
    vt[0] = '{1'b0, 8'h00, 8'h00, 8'h22, 8'h02, 8'hAA, 8'h11, 1'b0, 0, 3, 0};
    vt[1] = '{1'b0, 8'h00, 8'h01, 8'h25, 8'h03, 8'h00, 8'h00, 1'b0, 0, 4, 0};
    vt[2] = '{1'b0, 8'h00, 8'h01, 8'h25, 8'h03, 8'h00, 8'h00, 1'b0, 5, 4, 0};
    vt[3] = '{1'b0, 8'h00, 8'h00, 8'h40, 8'h81, 8'h5A, 8'h01, 1'b1, 0, 2, 0};
    vt[4] = '{1'b1, 8'h7F, 8'h00, 8'h33, 8'h00, 8'hC3, 8'h00, 1'b0, 0, 1, 1};
    vt[5] = '{1'b0, 8'h00, 8'h01, 8'h7E, 8'hFF, 8'h00, 8'h00, 1'b0, 0, 128, 0};
    vt[6] = '{1'b1, 8'hFF, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 2, 1, 1};
    vt[7] = '{1'b1, 8'h02, 8'h00, 8'h9C, 8'h04, 8'h01, 8'h23, 1'b1, 0, 5, 1};

    reset_i     = 1'b1;
    I_cmd_data  = 8'h00;
    I_cmd_valid = 1'b0;
    I_rsp_ready = 1'b1;
    repeat (3) @(negedge cwusb_clk);
    chk("rst_cmd_ready", 32'(O_cmd_ready), 0);
    chk("rst_rsp_valid", 32'(O_rsp_valid), 0);
    chk("rst_rsp_data", 32'(O_rsp_data), 0);
    chk("rst_reg_read", 32'(reg_read), 0);
    chk("rst_reg_write", 32'(reg_write), 0);
    chk("rst_addrvalid", 32'(reg_addrvalid), 0);
    chk("rst_address", 32'(reg_address), 0);
    chk("rst_bytecnt", 32'(reg_bytecnt), 0);
    chk("rst_write_data", 32'(write_data), 0);
    chk("rst_busy", 32'(O_busy), 0);
    chk("rst_bad_opcode", 32'(O_bad_opcode), 0);
    reset_i = 1'b0;

    fork
      monitor();
    join_none

    foreach (vt[i]) run_vec(vt[i]);

    // Reset after the 2nd of 4 write-data bytes; nothing more may reach the bus.
    begin
      int b_wr;
      b_wr = n_wr;
      rsp_stall = 0;
      cmd_q.delete();
      cmd_q.push_back(8'h00);
      cmd_q.push_back(8'h30);
      cmd_q.push_back(8'h03);
      cmd_q.push_back(8'h11);
      cmd_q.push_back(8'h22);
      exp_wr.push_back('{8'h30, W'(0), 8'h11});
      exp_wr.push_back('{8'h30, W'(1), 8'h22});
      drive(1'b0, 2, 200);
      reset_i = 1'b1;
      @(negedge cwusb_clk);
      chk("midrst_reg_write", 32'(reg_write), 0);
      chk("midrst_reg_read", 32'(reg_read), 0);
      chk("midrst_addrvalid", 32'(reg_addrvalid), 0);
      chk("midrst_rsp_valid", 32'(O_rsp_valid), 0);
      chk("midrst_cmd_ready", 32'(O_cmd_ready), 0);
      reset_i = 1'b0;
      repeat (10) @(negedge cwusb_clk);
      chk("midrst_n_writes", n_wr - b_wr, 2);
      chk("midrst_wr_queue", 32'(exp_wr.size()), 0);
    end
    run_vec('{1'b0, 8'h00, 8'h01, 8'h5D, 8'h02, 8'h00, 8'h00, 1'b0, 1, 3, 0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/reg_bus_master.md
Name: reg_bus_master

Overview:
Initiator for the shared register bus that every reg_* slave block decodes (reg_address, reg_bytecnt, reg_read, reg_write, write_data, read_data, reg_addrvalid). It parses a byte-stream command channel (host endpoint FIFO side) into multi-byte register read/write bursts. It returns read bytes on a response stream. It sits between the USB endpoint FIFOs and the OR-combined read_data of all register slaves.

Parameters:
pBYTECNT_SIZE, 7, width of reg_bytecnt; maximum burst = 2^pBYTECNT_SIZE bytes (128).

Ports:
cwusb_clk  input  1  sole clock
reset_i  input  1  synchronous, active-high reset
I_cmd_data  input  8  command/write-data byte stream
I_cmd_valid  input  1  I_cmd_data valid
O_cmd_ready  output  1  byte accepted when valid & ready
O_rsp_data  output  8  read response byte
O_rsp_valid  output  1  O_rsp_data valid
I_rsp_ready  input  1  response consumer ready
reg_address  output  8  register address, stable while reg_addrvalid=1
reg_bytecnt  output  pBYTECNT_SIZE  byte index within burst
write_data  output  8  write byte, valid with reg_write
read_data  input  8  OR of slave read data (slaves drive 0 when unselected)
reg_read  output  1  one-cycle read strobe
reg_write  output  1  one-cycle write strobe
reg_addrvalid  output  1  transaction-in-progress qualifier
O_busy  output  1  high in any state other than S_OPCODE
O_bad_opcode  output  1  one-cycle pulse on illegal opcode

Behaviour:
- Command format: byte0 opcode (0x00 = write, 0x01 = read), byte1 address, byte2 length L. Burst count N = L[pBYTECNT_SIZE-1:0]+1 (1..128). Higher bits of L are ignored. A write command is followed by N data bytes.
- All bus outputs are registered. Reset values: every output 0, O_cmd_ready 0, state S_OPCODE.
- S_OPCODE: O_cmd_ready=1.
  - On handshake with 0x00 or 0x01: latch direction, go to S_ADDR.
  - Any other value: byte is dropped, O_bad_opcode pulses the next cycle, stay in S_OPCODE.
- S_ADDR: O_cmd_ready=1. On handshake, latch reg_address, go to S_LEN.
- S_LEN: O_cmd_ready=1. On handshake, latch N, idx=0.
  - reg_addrvalid rises the following cycle.
  - Next state is S_WR (write) or S_RD_STROBE (read).
- S_WR: O_cmd_ready=1.
  - Each handshake on cycle t produces, on cycle t+1: reg_write=1, write_data=byte, reg_bytecnt=idx. Then idx increments.
  - Stalls (I_cmd_valid=0) insert idle cycles with reg_write=0; reg_addrvalid stays high.
  - O_cmd_ready drops the cycle after the Nth handshake. Next state S_END.
- S_RD_STROBE: O_cmd_ready=0, reg_read=1 for exactly one cycle with reg_bytecnt=idx. Go to S_RD_CAP.
- S_RD_CAP: sample read_data in this cycle (one cycle after reg_read) into O_rsp_data. Go to S_RD_OUT.
- S_RD_OUT: O_rsp_valid=1, O_rsp_data held stable until I_rsp_ready. On handshake:
  - idx < N-1: idx++, go to S_RD_STROBE.
  - otherwise: go to S_END.
  - Exactly one reg_read is issued per response byte; reads are never speculative.
- S_END: reg_addrvalid=0 for one cycle, then S_OPCODE. This guarantees at least one cycle low between transactions.
- reg_address and reg_bytecnt hold their last values between strobes and are only meaningful while reg_addrvalid=1.
- reg_read and reg_write are never high in the same cycle.
- reset_i mid-burst: the partial command is discarded. All strobes, reg_addrvalid and O_rsp_valid are 0 on the next cycle. No further bus activity occurs from the aborted command.
- Bytes arriving in S_RD_* are back-pressured (O_cmd_ready=0), not dropped.

Test Plan:
- Write 0x00,0x22,0x02,0xAA,0xBB,0xCC, continuous valid -> reg_addrvalid rises 1 cycle after length accept, 3 consecutive reg_write pulses with (bytecnt,data)=(0,AA),(1,BB),(2,CC) at address 0x22, reg_addrvalid low 1 cycle later, O_busy then 0.
- Read 0x01,0x25,0x03 with model slave returning 0x10+bytecnt one cycle after reg_read, I_rsp_ready=1 -> 4 reg_read pulses, bytecnt 0..3, responses 0x10,0x11,0x12,0x13.
- Same read with I_rsp_ready low 5 cycles per byte -> O_rsp_data stable while valid, next reg_read only after each handshake, still exactly 4 reg_read pulses.
- Write with I_cmd_valid toggling every other cycle, L=0x81 (N=2) -> exactly 2 writes, bytecnt 0,1, reg_addrvalid continuous throughout.
- Opcode 0x7F followed by a valid write command -> one O_bad_opcode pulse, no bus activity for 0x7F, following write executes correctly.
- reset_i asserted after 2nd of 4 write-data bytes -> no further reg_write, reg_addrvalid=0 next cycle, subsequent fresh read command completes normally.
